// File: rtl/paddle_accel.sv
// paddle_accel: clamped, accelerating paddle with look-ahead collision sensing, updated once per frame
module paddle_accel #(
  parameter int XLOC_START   = 320,
  parameter int YLOC_START   = 400,
  parameter int XHALF        = 5,
  parameter int YHALF        = 2,
  parameter int XMIN         = 8,
  parameter int XMAX         = 631,
  parameter int YMIN         = 8,
  parameter int YMAX         = 471,
  parameter int VMAX         = 4,
  parameter int ACCEL_FRAMES = 8
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       pixpulse,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       empty,
  input  logic       move,
  input  logic [3:0] move_dir,
  output logic       draw_paddle,
  output logic [9:0] xloc,
  output logic [9:0] yloc,
  output logic [3:0] speed,
  output logic [3:0] blocked
);
  localparam logic [3:0] VM = 4'(VMAX);
  logic [9:0] xloc_q, xloc_d, yloc_q, yloc_d;
  logic [3:0] speed_q, speed_d, blocked_q, blocked_d, pending_q, pending_d, last_q, last_d, step, hit;
  logic [7:0] streak_q, streak_d;
  logic [3:0][3:0] free_q, free_d, room;
  logic [3:0][10:0] dm1;
  logic valid_q, valid_d, fs, rows, cols;
  logic signed [10:0] h, v, lft, rgt, top, bot;
  function automatic logic [3:0] sat(input logic signed [10:0] r);
    return r < 0 ? 4'd0 : r > 11'sd15 ? 4'd15 : r[3:0];
  endfunction
  function automatic logic [3:0] min4(input logic [3:0] a, input logic [3:0] b);
    return a < b ? a : b;
  endfunction
  assign fs = pixpulse && hcount == 10'd0 && vcount == 10'd0;
  assign h = 11'(hcount);
  assign v = 11'(vcount);
  assign draw_paddle = 11'(hcount) + 11'(XHALF) >= 11'(xloc_q) && 11'(hcount) <= 11'(xloc_q) + 11'(XHALF) &&
                       11'(vcount) + 11'(YHALF) >= 11'(yloc_q) && 11'(vcount) <= 11'(yloc_q) + 11'(YHALF);
  assign xloc = xloc_q;
  assign yloc = yloc_q;
  assign speed = speed_q;
  assign blocked = blocked_q;
  always_comb begin
    room[0] = sat(11'(xloc_q) - 11'(XHALF + XMIN));
    room[1] = sat(11'(YMAX - YHALF) - 11'(yloc_q));
    room[2] = sat(11'(XMAX - XHALF) - 11'(xloc_q));
    room[3] = sat(11'(yloc_q) - 11'(YHALF + YMIN));
    step = '0;
    for (int i = 0; i < 4; i++)
      if (valid_q && pending_q[i]) step = min4(min4(speed_q, free_q[i]), room[i]);
    xloc_d = fs ? xloc_q + (pending_q[2] ? 10'(step) : 10'd0) - (pending_q[0] ? 10'(step) : 10'd0) : xloc_q;
    yloc_d = fs ? yloc_q + (pending_q[1] ? 10'(step) : 10'd0) - (pending_q[3] ? 10'(step) : 10'd0) : yloc_q;
    // bands follow the position that will be drawn this frame, so the FS pixel is sensed against the new spot
    lft = 11'(xloc_d) - 11'(XHALF);
    rgt = 11'(xloc_d) + 11'(XHALF);
    top = 11'(yloc_d) - 11'(YHALF);
    bot = 11'(yloc_d) + 11'(YHALF);
    rows = v >= top && v <= bot;
    cols = h >= lft && h <= rgt;
    dm1[0] = lft - h - 11'd1;
    dm1[1] = v - bot - 11'd1;
    dm1[2] = h - rgt - 11'd1;
    dm1[3] = top - v - 11'd1;
    for (int i = 0; i < 4; i++) begin
      hit[i] = ((i % 2 == 1) ? cols : rows) && dm1[i] < 11'(VMAX);
      free_d[i] = fs ? VM : free_q[i];
      if (pixpulse && !empty && hit[i] && 4'(dm1[i]) < free_d[i]) free_d[i] = 4'(dm1[i]);
      blocked_d[i] = fs ? free_q[i] == 4'd0 : blocked_q[i];
    end
    pending_d = fs ? 4'd0 : (pixpulse && move && $onehot(move_dir)) ? move_dir : pending_q;
    valid_d = valid_q | fs;
    speed_d = speed_q;
    streak_d = streak_q;
    last_d = last_q;
    if (fs) begin
      last_d = step != 4'd0 ? pending_q : 4'd0;
      if (pending_q == 4'd0 || step == 4'd0 || pending_q != last_q) begin
        speed_d = 4'd1;
        streak_d = '0;
      end else if (streak_q + 8'd1 == 8'(ACCEL_FRAMES - 1)) begin
        speed_d = speed_q < VM ? speed_q + 4'd1 : VM;
        streak_d = '0;
      end else begin
        streak_d = streak_q + 8'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      xloc_q <= 10'(XLOC_START);
      yloc_q <= 10'(YLOC_START);
      speed_q <= 4'd1;
      blocked_q <= '0;
      pending_q <= '0;
      last_q <= '0;
      streak_q <= '0;
      free_q <= {4{VM}};
      valid_q <= 1'b0;
    end else begin
      xloc_q <= xloc_d;
      yloc_q <= yloc_d;
      speed_q <= speed_d;
      blocked_q <= blocked_d;
      pending_q <= pending_d;
      last_q <= last_d;
      streak_q <= streak_d;
      free_q <= free_d;
      valid_q <= valid_d;
    end
  end
endmodule
